geom_store: RTL and testbench

Single-clock, parametrised successor to the SPI-side raster memory. Holds vertex and triangle RAMs, their per-buffer descriptor tables and a double-buffered instance table. Writes arrive through a ready/valid command and data stream from the decoded SPI front end. The frame driver reads through a pipelined instance-fetch channel and direct vertex/triangle read ports. Adds to the previous generation: backpressure, a frame-swap shadow instance bank and optional bounds checking.

---
 rtl/geom_store.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_geom_store.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/geom_store.sv
// geom_store: vertex/triangle RAMs, per-buffer descriptor tables and a double-buffered instance
// table behind a ready/valid write stream. Optional bounds checking: `GEOM_STORE_BOUNDS_CHECK_EN.
module geom_store #(
  parameter int MAX_VERT = 8192,
  parameter int MAX_TRI  = 8192,
  parameter int MAX_INST = 256,
  parameter int MAX_BUF  = 256,
  parameter int CNT_W    = 12,
  parameter int VTX_W    = 108,
  parameter int TRI_W    = 36,
  parameter int TRANS_W  = 384,
  parameter int VA_W     = $clog2(MAX_VERT),
  parameter int TA_W     = $clog2(MAX_TRI),
  parameter int IA_W     = $clog2(MAX_INST),
  parameter int ID_W     = $clog2(MAX_BUF),
  parameter int BASE_W   = (VA_W > TA_W) ? VA_W : TA_W,
  parameter int AUX_W    = IA_W + ID_W,
  parameter int DIN_W    = (((VTX_W > TRI_W) ? VTX_W : TRI_W) > TRANS_W) ?
                           ((VTX_W > TRI_W) ? VTX_W : TRI_W) : TRANS_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic [AUX_W-1:0]    cmd_aux,
  input  logic [BASE_W-1:0]   cmd_base,
  input  logic [CNT_W-1:0]    cmd_count,
  input  logic                dat_valid,
  output logic                dat_ready,
  input  logic [DIN_W-1:0]    dat_in,
  input  logic                frame_swap,
  output logic                bank_sel,
  input  logic                fetch_req,
  output logic                fetch_busy,
  input  logic [IA_W-1:0]     fetch_inst_id,
  output logic                fetch_valid,
  output logic [VA_W-1:0]     fetch_vbase,
  output logic [CNT_W-1:0]    fetch_vcount,
  output logic [TA_W-1:0]     fetch_tbase,
  output logic [CNT_W-1:0]    fetch_tcount,
  output logic [TRANS_W-1:0]  fetch_transform,
  output logic [2*ID_W-1:0]   fetch_ids,
  input  logic [VA_W-1:0]     vert_rd_addr,
  output logic [VTX_W-1:0]    vert_rd_data,
  input  logic [TA_W-1:0]     tri_rd_addr,
  output logic [TRI_W-1:0]    tri_rd_data,
  output logic                err_oob,
  input  logic                err_clr
);

  localparam int INST_W = TRANS_W + 2*ID_W;
  localparam int VD_W   = VA_W + CNT_W;
  localparam int TD_W   = TA_W + CNT_W;

  typedef enum logic [1:0] {IDLE, VERT_DATA, TRI_DATA, INST_DATA} state_t;

  state_t             state_q, state_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   ctr_q, ctr_d;
  logic               drop_q, drop_d;
  logic [ID_W-1:0]    vid_q, vid_d;
  logic [ID_W-1:0]    tid_q, tid_d;
  logic [IA_W-1:0]    iid_q, iid_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               dat_ready_q, dat_ready_d;

  logic               cmd_fire, dat_fire;
  logic               hdr_oob, inst_oob, oob_set;
  logic               vdesc_we, tdesc_we, vram_we, tram_we, inst_we;
  logic [BASE_W-1:0]  wr_addr;
  logic [ID_W-1:0]    aux_tri;
  logic [IA_W-1:0]    aux_inst;

  logic               fetch_accept, swap_evt;
  logic               s1_q, s1_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               bank_q, bank_d;
  logic               pend_q, pend_d;
  logic [VA_W-1:0]    vbase_q, vbase_d;
  logic [CNT_W-1:0]   vcount_q, vcount_d;
  logic [TA_W-1:0]    tbase_q, tbase_d;
  logic [CNT_W-1:0]   tcount_q, tcount_d;
  logic [TRANS_W-1:0] xform_q, xform_d;
  logic [2*ID_W-1:0]  ids_q, ids_d;

  logic [VTX_W-1:0]   vert_ram [MAX_VERT];
  logic [TRI_W-1:0]   tri_ram  [MAX_TRI];
  logic [VD_W-1:0]    vdesc_ram [MAX_BUF];
  logic [TD_W-1:0]    tdesc_ram [MAX_BUF];
  logic [INST_W-1:0]  inst_ram [2*MAX_INST];
  logic [VTX_W-1:0]   vert_rd_q;
  logic [TRI_W-1:0]   tri_rd_q;
  logic [INST_W-1:0]  inst_rd_q;

  assign aux_tri  = cmd_aux[ID_W-1:0];
  assign aux_inst = cmd_aux[ID_W +: IA_W];
  assign cmd_fire = cmd_valid & cmd_ready_q;
  assign dat_fire = dat_valid & dat_ready_q;
  // Power-of-two depths: truncating the sum gives the modulo-depth wrap.
  assign wr_addr  = base_q + BASE_W'(ctr_q);

`ifdef GEOM_STORE_BOUNDS_CHECK_EN
  logic [31:0] hdr_end;
  assign hdr_end  = 32'(cmd_base) + 32'(cmd_count);
  assign hdr_oob  = (cmd_op == 2'd0) ? (hdr_end > 32'(MAX_VERT)) : (hdr_end > 32'(MAX_TRI));
  assign inst_oob = (32'(aux_inst) >= 32'(MAX_INST)) || (32'(cmd_id) >= 32'(MAX_BUF)) ||
                    (32'(aux_tri) >= 32'(MAX_BUF));
`else
  assign hdr_oob  = 1'b0;
  assign inst_oob = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    ctr_d    = ctr_q;
    drop_d   = drop_q;
    vid_d    = vid_q;
    tid_d    = tid_q;
    iid_d    = iid_q;
    vdesc_we = 1'b0;
    tdesc_we = 1'b0;
    vram_we  = 1'b0;
    tram_we  = 1'b0;
    inst_we  = 1'b0;
    oob_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            2'd0, 2'd1: begin
              base_d   = cmd_base;
              count_d  = cmd_count;
              ctr_d    = '0;
              drop_d   = hdr_oob;
              oob_set  = hdr_oob;
              vdesc_we = (cmd_op == 2'd0) && !hdr_oob;
              tdesc_we = (cmd_op == 2'd1) && !hdr_oob;
              if (cmd_count != '0)
                state_d = (cmd_op == 2'd0) ? VERT_DATA : TRI_DATA;
            end
            2'd2: begin
              vid_d   = cmd_id;
              tid_d   = aux_tri;
              iid_d   = aux_inst;
              drop_d  = inst_oob;
              oob_set = inst_oob;
              state_d = INST_DATA;
            end
            default: ;
          endcase
        end
      end
      VERT_DATA, TRI_DATA: begin
        if (dat_fire) begin
          vram_we = (state_q == VERT_DATA) && !drop_q;
          tram_we = (state_q == TRI_DATA) && !drop_q;
          ctr_d   = ctr_q + CNT_W'(1);
          if (ctr_q == count_q - CNT_W'(1))
            state_d = IDLE;
        end
      end
      INST_DATA: begin
        if (dat_fire) begin
          inst_we = !drop_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    dat_ready_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      ctr_q       <= '0;
      drop_q      <= 1'b0;
      vid_q       <= '0;
      tid_q       <= '0;
      iid_q       <= '0;
      cmd_ready_q <= 1'b1;
      dat_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      ctr_q       <= ctr_d;
      drop_q      <= drop_d;
      vid_q       <= vid_d;
      tid_q       <= tid_d;
      iid_q       <= iid_d;
      cmd_ready_q <= cmd_ready_d;
      dat_ready_q <= dat_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (vram_we)
      vert_ram[wr_addr[VA_W-1:0]] <= dat_in[VTX_W-1:0];
    vert_rd_q <= vert_ram[vert_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (tram_we)
      tri_ram[wr_addr[TA_W-1:0]] <= dat_in[TRI_W-1:0];
    tri_rd_q <= tri_ram[tri_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (vdesc_we)
      vdesc_ram[cmd_id] <= {cmd_base[VA_W-1:0], cmd_count};
    if (tdesc_we)
      tdesc_ram[cmd_id] <= {cmd_base[TA_W-1:0], cmd_count};
  end

  // Bank index is the MSB: writes land in the shadow bank, fetches read the front bank.
  always_ff @(posedge clk) begin
    if (inst_we)
      inst_ram[{~bank_q, iid_q}] <= {dat_in[TRANS_W-1:0], vid_q, tid_q};
    inst_rd_q <= inst_ram[{bank_q, fetch_inst_id}];
  end

  always_comb begin
    fetch_accept = fetch_req & ~busy_q;
    s1_d     = fetch_accept;
    busy_d   = fetch_accept | s1_q;
    valid_d  = s1_q;
    vbase_d  = vbase_q;
    vcount_d = vcount_q;
    tbase_d  = tbase_q;
    tcount_d = tcount_q;
    xform_d  = xform_q;
    ids_d    = ids_q;
    if (s1_q) begin
      {vbase_d, vcount_d} = vdesc_ram[inst_rd_q[2*ID_W-1:ID_W]];
      {tbase_d, tcount_d} = tdesc_ram[inst_rd_q[ID_W-1:0]];
      xform_d = inst_rd_q[INST_W-1:2*ID_W];
      ids_d   = inst_rd_q[2*ID_W-1:0];
    end
    // A swap never lands while a fetch is in flight or being accepted.
    swap_evt = frame_swap | pend_q;
    bank_d   = bank_q;
    pend_d   = swap_evt;
    if (swap_evt && !busy_q && !fetch_accept) begin
      bank_d = ~bank_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      bank_q   <= 1'b0;
      pend_q   <= 1'b0;
      vbase_q  <= '0;
      vcount_q <= '0;
      tbase_q  <= '0;
      tcount_q <= '0;
      xform_q  <= '0;
      ids_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      bank_q   <= bank_d;
      pend_q   <= pend_d;
      vbase_q  <= vbase_d;
      vcount_q <= vcount_d;
      tbase_q  <= tbase_d;
      tcount_q <= tcount_d;
      xform_q  <= xform_d;
      ids_q    <= ids_d;
    end
  end

`ifdef GEOM_STORE_BOUNDS_CHECK_EN
  logic err_q, err_d;
  always_comb begin
    err_d = err_q;
    if (err_clr)
      err_d = 1'b0;
    if (oob_set)
      err_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end
  assign err_oob = err_q;
`else
  logic unused_bounds;
  assign unused_bounds = err_clr | oob_set;
  assign err_oob = 1'b0;
`endif

  assign cmd_ready       = cmd_ready_q;
  assign dat_ready       = dat_ready_q;
  assign bank_sel        = bank_q;
  assign fetch_busy      = busy_q;
  assign fetch_valid     = valid_q;
  assign fetch_vbase     = vbase_q;
  assign fetch_vcount    = vcount_q;
  assign fetch_tbase     = tbase_q;
  assign fetch_tcount    = tcount_q;
  assign fetch_transform = xform_q;
  assign fetch_ids       = ids_q;
  assign vert_rd_data    = vert_rd_q;
  assign tri_rd_data     = tri_rd_q;

endmodule

// File: tb/tb_geom_store.sv
// Directed self-checking bench for geom_store (default parameters).
module tb_geom_store;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [7:0]   cmd_id;
  logic [15:0]  cmd_aux;
  logic [12:0]  cmd_base;
  logic [11:0]  cmd_count;
  logic         dat_valid, dat_ready;
  logic [383:0] dat_in;
  logic         frame_swap, bank_sel;
  logic         fetch_req, fetch_busy;
  logic [7:0]   fetch_inst_id;
  logic         fetch_valid;
  logic [12:0]  fetch_vbase, fetch_tbase;
  logic [11:0]  fetch_vcount, fetch_tcount;
  logic [383:0] fetch_transform;
  logic [15:0]  fetch_ids;
  logic [12:0]  vert_rd_addr, tri_rd_addr;
  logic [107:0] vert_rd_data;
  logic [35:0]  tri_rd_data;
  logic         err_oob, err_clr;

  int checks = 0;
  int errors = 0;
  logic [383:0] t1, t2, t3;

  geom_store dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_id(cmd_id),
    .cmd_aux(cmd_aux), .cmd_base(cmd_base), .cmd_count(cmd_count),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_in(dat_in),
    .frame_swap(frame_swap), .bank_sel(bank_sel),
    .fetch_req(fetch_req), .fetch_busy(fetch_busy), .fetch_inst_id(fetch_inst_id),
    .fetch_valid(fetch_valid), .fetch_vbase(fetch_vbase), .fetch_vcount(fetch_vcount),
    .fetch_tbase(fetch_tbase), .fetch_tcount(fetch_tcount),
    .fetch_transform(fetch_transform), .fetch_ids(fetch_ids),
    .vert_rd_addr(vert_rd_addr), .vert_rd_data(vert_rd_data),
    .tri_rd_addr(tri_rd_addr), .tri_rd_data(tri_rd_data),
    .err_oob(err_oob), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] id, input logic [15:0] aux,
                          input logic [12:0] base, input logic [11:0] cnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_id = id; cmd_aux = aux; cmd_base = base; cmd_count = cnt;
    tick();
    cmd_valid = 1'b0;
    $display("cmd op=%0d id=%0d aux=%h base=%0d count=%0d", op, id, aux, base, cnt);
  endtask

  task automatic send_beat(input logic [383:0] d);
    dat_valid = 1'b1; dat_in = d;
    tick();
    dat_valid = 1'b0;
  endtask

  task automatic start_fetch(input logic [7:0] id);
    fetch_req = 1'b1; fetch_inst_id = id;
    tick();
    fetch_req = 1'b0;
    $display("fetch id=%0d", id);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (dat_ready !== 1'b0) begin errors++; $display("FAIL reset_dat_ready: got %b want 0", dat_ready); end
    checks++; if (bank_sel !== 1'b0) begin errors++; $display("FAIL reset_bank_sel: got %b want 0", bank_sel); end
    checks++; if (fetch_busy !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_flags: got busy=%b valid=%b want 0 0", fetch_busy, fetch_valid); end
    checks++; if (fetch_vbase !== 13'd0 || fetch_tcount !== 12'd0 || fetch_ids !== 16'd0 || fetch_transform !== 384'd0) begin errors++; $display("FAIL reset_fetch_data: got vbase=%0d tcount=%0d ids=%h want 0", fetch_vbase, fetch_tcount, fetch_ids); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL reset_err_oob: got %b want 0", err_oob); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_vertex();
    send_cmd(2'd0, 8'd3, 16'd0, 13'd100, 12'd4);
    checks++; if (dat_ready !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL vert_hdr_ready: got dat=%b cmd=%b want 1 0", dat_ready, cmd_ready); end
    for (int i = 0; i < 4; i++) send_beat(384'(10 + i));
    checks++; if (cmd_ready !== 1'b1 || dat_ready !== 1'b0) begin errors++; $display("FAIL vert_burst_end: got cmd=%b dat=%b want 1 0", cmd_ready, dat_ready); end
    for (int i = 0; i < 4; i++) begin
      vert_rd_addr = 13'(100 + i);
      tick();
      checks++; if (vert_rd_data !== 108'(10 + i)) begin errors++; $display("FAIL vert_read_%0d: got %h want %h", 100 + i, vert_rd_data, 10 + i); end
    end
  endtask

  task automatic test_tri();
    send_cmd(2'd1, 8'd7, 16'd0, 13'd200, 12'd2);
    send_beat(384'h1_2345_6789);
    send_beat(384'hA_BCDE_F012);
    tri_rd_addr = 13'd200;
    tick();
    checks++; if (tri_rd_data !== 36'h1_2345_6789) begin errors++; $display("FAIL tri_read_200: got %h want 123456789", tri_rd_data); end
    tri_rd_addr = 13'd201;
    tick();
    checks++; if (tri_rd_data !== 36'hA_BCDE_F012) begin errors++; $display("FAIL tri_read_201: got %h want abcdef012", tri_rd_data); end
  endtask

  task automatic test_count0();
    send_cmd(2'd0, 8'd9, 16'd0, 13'd50, 12'd0);
    checks++; if (cmd_ready !== 1'b1 || dat_ready !== 1'b0) begin errors++; $display("FAIL count0_idle: got cmd=%b dat=%b want 1 0", cmd_ready, dat_ready); end
    send_cmd(2'd1, 8'd8, 16'd0, 13'd300, 12'd1);
    checks++; if (dat_ready !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL count0_next_cmd: got dat=%b cmd=%b want 1 0", dat_ready, cmd_ready); end
    send_beat(384'h5);
    send_cmd(2'd3, 8'd1, 16'h0101, 13'd1, 12'd1);
    checks++; if (cmd_ready !== 1'b1 || dat_ready !== 1'b0) begin errors++; $display("FAIL reserved_op: got cmd=%b dat=%b want 1 0", cmd_ready, dat_ready); end
  endtask

  task automatic test_inst_fetch();
    send_cmd(2'd2, 8'd3, {8'd5, 8'd7}, 13'd0, 12'd0);
    checks++; if (dat_ready !== 1'b1) begin errors++; $display("FAIL inst_dat_ready: got %b want 1", dat_ready); end
    send_beat(t1);
    frame_swap = 1'b1; tick(); frame_swap = 1'b0;
    checks++; if (bank_sel !== 1'b1) begin errors++; $display("FAIL swap_idle: got bank_sel=%b want 1", bank_sel); end
    start_fetch(8'd5);
    checks++; if (fetch_busy !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("FAIL fetch_n1: got busy=%b valid=%b want 1 0", fetch_busy, fetch_valid); end
    tick();
    checks++; if (fetch_busy !== 1'b1 || fetch_valid !== 1'b1) begin errors++; $display("FAIL fetch_n2: got busy=%b valid=%b want 1 1", fetch_busy, fetch_valid); end
    checks++; if (fetch_transform !== t1) begin errors++; $display("FAIL fetch_transform: got %h want %h", fetch_transform, t1); end
    checks++; if (fetch_ids !== 16'h0307) begin errors++; $display("FAIL fetch_ids: got %h want 0307", fetch_ids); end
    checks++; if (fetch_vbase !== 13'd100 || fetch_vcount !== 12'd4) begin errors++; $display("FAIL fetch_vdesc: got %0d/%0d want 100/4", fetch_vbase, fetch_vcount); end
    checks++; if (fetch_tbase !== 13'd200 || fetch_tcount !== 12'd2) begin errors++; $display("FAIL fetch_tdesc: got %0d/%0d want 200/2", fetch_tbase, fetch_tcount); end
    tick();
    checks++; if (fetch_busy !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL fetch_n3: got busy=%b valid=%b want 0 0", fetch_busy, fetch_valid); end
  endtask

  task automatic test_swap_during_fetch();
    send_cmd(2'd2, 8'd9, {8'd5, 8'd8}, 13'd0, 12'd0);
    send_beat(t2);
    fetch_req = 1'b1; fetch_inst_id = 8'd5; frame_swap = 1'b1;
    tick();
    fetch_req = 1'b0; frame_swap = 1'b0;
    checks++; if (bank_sel !== 1'b1) begin errors++; $display("FAIL swap_held_n1: got bank_sel=%b want 1", bank_sel); end
    tick();
    checks++; if (fetch_valid !== 1'b1 || fetch_transform !== t1) begin errors++; $display("FAIL swap_fetch_old_bank: got valid=%b xform=%h want 1 %h", fetch_valid, fetch_transform, t1); end
    checks++; if (bank_sel !== 1'b1) begin errors++; $display("FAIL swap_held_n2: got bank_sel=%b want 1", bank_sel); end
    tick(); tick();
    checks++; if (bank_sel !== 1'b0) begin errors++; $display("FAIL swap_applied: got bank_sel=%b want 0", bank_sel); end
    start_fetch(8'd5);
    tick();
    checks++; if (fetch_valid !== 1'b1 || fetch_transform !== t2 || fetch_ids !== 16'h0908) begin errors++; $display("FAIL fetch_new_bank: got valid=%b ids=%h want 1 0908", fetch_valid, fetch_ids); end
    checks++; if (fetch_vbase !== 13'd50 || fetch_vcount !== 12'd0 || fetch_tbase !== 13'd300 || fetch_tcount !== 12'd1) begin errors++; $display("FAIL fetch_new_desc: got %0d/%0d %0d/%0d want 50/0 300/1", fetch_vbase, fetch_vcount, fetch_tbase, fetch_tcount); end
    tick();
  endtask

  task automatic test_swap_inst_write();
    send_cmd(2'd2, 8'd3, {8'd2, 8'd7}, 13'd0, 12'd0);
    frame_swap = 1'b1;
    send_beat(t3);
    frame_swap = 1'b0;
    checks++; if (bank_sel !== 1'b1) begin errors++; $display("FAIL swap_with_write: got bank_sel=%b want 1", bank_sel); end
    start_fetch(8'd2);
    tick();
    checks++; if (fetch_valid !== 1'b1 || fetch_transform !== t3 || fetch_ids !== 16'h0307) begin errors++; $display("FAIL swap_write_bank: got valid=%b ids=%h want 1 0307", fetch_valid, fetch_ids); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    send_cmd(2'd0, 8'd4, 16'd0, 13'd500, 12'd4);
    send_beat(384'h11);
    send_beat(384'h22);
    rst_n = 1'b0;
    #2;
    checks++; if (cmd_ready !== 1'b1 || dat_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got cmd=%b dat=%b want 1 0", cmd_ready, dat_ready); end
    checks++; if (bank_sel !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL midrst_fetch: got bank=%b valid=%b want 0 0", bank_sel, fetch_valid); end
    rst_n = 1'b1;
    tick();
    vert_rd_addr = 13'd500;
    tick();
    checks++; if (vert_rd_data !== 108'h11) begin errors++; $display("FAIL midrst_word0: got %h want 11", vert_rd_data); end
    vert_rd_addr = 13'd501;
    tick();
    checks++; if (vert_rd_data !== 108'h22) begin errors++; $display("FAIL midrst_word1: got %h want 22", vert_rd_data); end
  endtask

`ifdef GEOM_STORE_BOUNDS_CHECK_EN
  task automatic test_bounds();
    logic [12:0] addrs [4];
    addrs[0] = 13'd8190; addrs[1] = 13'd8191; addrs[2] = 13'd0; addrs[3] = 13'd1;
    send_cmd(2'd0, 8'd1, 16'd0, 13'd8190, 12'd2);
    send_beat(384'h51); send_beat(384'h52);
    send_cmd(2'd0, 8'd2, 16'd0, 13'd0, 12'd2);
    send_beat(384'h53); send_beat(384'h54);
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_inbounds: got %b want 0", err_oob); end
    send_cmd(2'd0, 8'd1, 16'd0, 13'd8190, 12'd4);
    checks++; if (err_oob !== 1'b1 || dat_ready !== 1'b1) begin errors++; $display("FAIL oob_set: got err=%b dat=%b want 1 1", err_oob, dat_ready); end
    for (int i = 0; i < 4; i++) send_beat(384'(8'hE1 + i));
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL oob_consumed: got cmd_ready=%b want 1", cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      vert_rd_addr = addrs[i];
      tick();
      checks++; if (vert_rd_data !== 108'(8'h51 + i)) begin errors++; $display("FAIL oob_ram_%0d: got %h want %h", addrs[i], vert_rd_data, 8'h51 + i); end
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_clear: got %b want 0", err_oob); end
  endtask
`else
  task automatic test_wrap();
    logic [12:0] addrs [4];
    addrs[0] = 13'd8190; addrs[1] = 13'd8191; addrs[2] = 13'd0; addrs[3] = 13'd1;
    send_cmd(2'd0, 8'd1, 16'd0, 13'd8190, 12'd4);
    for (int i = 0; i < 4; i++) send_beat(384'(8'h61 + i));
    for (int i = 0; i < 4; i++) begin
      vert_rd_addr = addrs[i];
      tick();
      checks++; if (vert_rd_data !== 108'(8'h61 + i)) begin errors++; $display("FAIL wrap_%0d: got %h want %h", addrs[i], vert_rd_data, 8'h61 + i); end
    end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL wrap_err_oob: got %b want 0", err_oob); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_id = '0; cmd_aux = '0; cmd_base = '0;
    cmd_count = '0; dat_valid = 1'b0; dat_in = '0; frame_swap = 1'b0; fetch_req = 1'b0;
    fetch_inst_id = '0; vert_rd_addr = '0; tri_rd_addr = '0; err_clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      t1[i*32 +: 32] = 32'h1000_0000 + 32'(i);
      t2[i*32 +: 32] = 32'h2000_0000 + 32'(i * 3);
      t3[i*32 +: 32] = 32'h3000_0000 ^ 32'(i * 7);
    end
    test_reset();
    test_vertex();
    test_tri();
    test_count0();
    test_inst_fetch();
    test_swap_during_fetch();
    test_swap_inst_write();
    test_reset_mid_burst();
`ifdef GEOM_STORE_BOUNDS_CHECK_EN
    test_bounds();
`else
    test_wrap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
